// File: rtl/alu_issue_if.sv
// Decode/execute handshake bundle for the ALU issue stage.
// The slave modport is the stage. The master modport is the surrounding pipeline.
interface alu_issue_if #(
   parameter int DATA_W      = 32,
   parameter int STALL_CNT_W = 16
);
   logic                   flush;
   logic                   id_valid;
   logic                   id_ready;
   logic [3:0]             id_alu_op;
   logic [DATA_W-1:0]      id_rs_val;
   logic [DATA_W-1:0]      id_rt_val;
   logic [15:0]            id_imm;
   logic                   id_imm_sext;
   logic [4:0]             id_shamt;
   logic                   id_a_src;
   logic [1:0]             id_b_src;
   logic [4:0]             id_rd;
   logic                   id_wr_en;
   logic [1:0]             fwd_rs_sel;
   logic [1:0]             fwd_rt_sel;
   logic [DATA_W-1:0]      exmem_fwd;
   logic [DATA_W-1:0]      memwb_fwd;
   logic                   ex_valid;
   logic                   ex_ready;
   logic [3:0]             alu_opcode;
   logic [DATA_W-1:0]      alu_inpA;
   logic [DATA_W-1:0]      alu_inpB;
   logic [4:0]             ex_rd;
   logic                   ex_wr_en;
   logic [STALL_CNT_W-1:0] stall_cnt;

   modport slave (
      input  flush, id_valid, id_alu_op, id_rs_val, id_rt_val, id_imm, id_imm_sext,
             id_shamt, id_a_src, id_b_src, id_rd, id_wr_en, fwd_rs_sel, fwd_rt_sel,
             exmem_fwd, memwb_fwd, ex_ready,
      output id_ready, ex_valid, alu_opcode, alu_inpA, alu_inpB, ex_rd, ex_wr_en, stall_cnt
   );

   modport master (
      output flush, id_valid, id_alu_op, id_rs_val, id_rt_val, id_imm, id_imm_sext,
             id_shamt, id_a_src, id_b_src, id_rd, id_wr_en, fwd_rs_sel, fwd_rt_sel,
             exmem_fwd, memwb_fwd, ex_ready,
      input  id_ready, ex_valid, alu_opcode, alu_inpA, alu_inpB, ex_rd, ex_wr_en, stall_cnt
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU. Operand forwarding and immediate/shamt muxing are resolved
// at capture time, so the ALU sees only registered inputs.
module alu_issue_stage #(
   parameter int DATA_W      = 32,
   parameter int STALL_CNT_W = 16
) (
   input logic        clk,
   input logic        rst_n,
   alu_issue_if.slave bus
);
   localparam logic [3:0] OP_BUBBLE = 4'b1111;

   logic                   ex_valid_q;
   logic [3:0]             opcode_q;
   logic [DATA_W-1:0]      inp_a_q, inp_b_q;
   logic [4:0]             rd_q;
   logic                   wr_en_q;
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   logic [DATA_W-1:0] rs_f, rt_f, imm_ext, a_d, b_d;
   logic              id_ready;

   assign id_ready = !ex_valid_q || bus.ex_ready;

   always_comb begin
      rs_f = bus.id_rs_val;
      case (bus.fwd_rs_sel)
         2'b01:   rs_f = bus.exmem_fwd;
         2'b10:   rs_f = bus.memwb_fwd;
         default: rs_f = bus.id_rs_val;
      endcase
      rt_f = bus.id_rt_val;
      case (bus.fwd_rt_sel)
         2'b01:   rt_f = bus.exmem_fwd;
         2'b10:   rt_f = bus.memwb_fwd;
         default: rt_f = bus.id_rt_val;
      endcase
      imm_ext = bus.id_imm_sext ? {{(DATA_W-16){bus.id_imm[15]}}, bus.id_imm}
                                : {{(DATA_W-16){1'b0}}, bus.id_imm};
      a_d = bus.id_a_src ? rt_f : rs_f;
      b_d = rt_f;
      case (bus.id_b_src)
         2'b01:   b_d = imm_ext;
         2'b10:   b_d = {{(DATA_W-5){1'b0}}, bus.id_shamt};
         2'b11:   b_d = rs_f;
         default: b_d = rt_f;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q  <= 1'b0;
         opcode_q    <= OP_BUBBLE;
         inp_a_q     <= '0;
         inp_b_q     <= '0;
         rd_q        <= '0;
         wr_en_q     <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         // Flush edges still count as stalled when the held entry was blocked.
         if (ex_valid_q && !bus.ex_ready && stall_cnt_q != {STALL_CNT_W{1'b1}})
            stall_cnt_q <= stall_cnt_q + 1'b1;

         if (bus.flush) begin
            ex_valid_q <= 1'b0;
            opcode_q   <= OP_BUBBLE;
            wr_en_q    <= 1'b0;
         end else if (bus.id_valid && id_ready) begin
            ex_valid_q <= 1'b1;
            opcode_q   <= bus.id_alu_op;
            inp_a_q    <= a_d;
            inp_b_q    <= b_d;
            rd_q       <= bus.id_rd;
            wr_en_q    <= bus.id_wr_en;
         end else if (ex_valid_q && bus.ex_ready && !bus.id_valid) begin
            ex_valid_q <= 1'b0;
            opcode_q   <= OP_BUBBLE;
            wr_en_q    <= 1'b0;
         end
      end
   end

   assign bus.id_ready   = id_ready;
   assign bus.ex_valid   = ex_valid_q;
   assign bus.alu_opcode = opcode_q;
   assign bus.alu_inpA   = inp_a_q;
   assign bus.alu_inpB   = inp_b_q;
   assign bus.ex_rd      = rd_q;
   assign bus.ex_wr_en   = wr_en_q;
   assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: inputs change 1 ns after a rising edge and are
// sampled 1 ns after the following edge.
module tb_alu_issue_stage;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_issue_if #(.DATA_W(32), .STALL_CNT_W(16)) bus ();

   alu_issue_stage #(.DATA_W(32), .STALL_CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [15:0] imm, input logic sext, input logic [4:0] shamt,
                        input logic asrc, input logic [1:0] bsrc, input logic [4:0] rd,
                        input logic wr);
      bus.id_valid    = 1'b1;
      bus.id_alu_op   = op;
      bus.id_rs_val   = rs;
      bus.id_rt_val   = rt;
      bus.id_imm      = imm;
      bus.id_imm_sext = sext;
      bus.id_shamt    = shamt;
      bus.id_a_src    = asrc;
      bus.id_b_src    = bsrc;
      bus.id_rd       = rd;
      bus.id_wr_en    = wr;
      bus.fwd_rs_sel  = 2'b00;
      bus.fwd_rt_sel  = 2'b00;
   endtask

   task automatic test_reset();
      drive(4'b0010, 32'h11, 32'h22, 16'h0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd3, 1'b1);
      bus.ex_ready = 1'b0;
      step();
      step();
      step();
      bus.id_valid = 1'b0;
      // Assert reset mid-cycle, well away from any clock edge.
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0b want 0", bus.ex_valid); end
      checks++;
      if (bus.alu_opcode !== 4'hF) begin errors++; $display("FAIL reset_opcode got %h want f", bus.alu_opcode); end
      checks++;
      if (bus.stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt got %h want 0", bus.stall_cnt); end
      checks++;
      if (bus.alu_inpA !== 32'h0 || bus.alu_inpB !== 32'h0 || bus.ex_wr_en !== 1'b0 || bus.ex_rd !== 5'd0) begin
         errors++;
         $display("FAIL reset_operands got A=%h B=%h wr=%0b rd=%0d want 0", bus.alu_inpA, bus.alu_inpB, bus.ex_wr_en, bus.ex_rd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.ex_ready = 1'b1;
      step();
   endtask

   task automatic test_add_imm();
      drive(4'b0101, 32'h5, 32'h0, 16'hFFFF, 1'b1, 5'd0, 1'b0, 2'b01, 5'd9, 1'b1);
      step();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.alu_opcode !== 4'b0101 || bus.alu_inpA !== 32'h5 ||
          bus.alu_inpB !== 32'hFFFFFFFF || bus.ex_rd !== 5'd9 || bus.ex_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL add_sext got v=%0b op=%h A=%h B=%h rd=%0d wr=%0b want 1 5 5 ffffffff 9 1",
                  bus.ex_valid, bus.alu_opcode, bus.alu_inpA, bus.alu_inpB, bus.ex_rd, bus.ex_wr_en);
      end
      bus.id_imm_sext = 1'b0;
      step();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.alu_inpB !== 32'h0000FFFF) begin
         errors++;
         $display("FAIL add_zext got v=%0b B=%h want 1 0000ffff", bus.ex_valid, bus.alu_inpB);
      end
      bus.id_valid = 1'b0;
      step();
      checks++;
      if (bus.ex_valid !== 1'b0 || bus.alu_opcode !== 4'hF || bus.ex_wr_en !== 1'b0 || bus.alu_inpA !== 32'h5) begin
         errors++;
         $display("FAIL drain_bubble got v=%0b op=%h wr=%0b A=%h want 0 f 0 5",
                  bus.ex_valid, bus.alu_opcode, bus.ex_wr_en, bus.alu_inpA);
      end
   endtask

   task automatic test_forwarding();
      logic [31:0] exp_a;
      bus.exmem_fwd = 32'h10;
      bus.memwb_fwd = 32'h20;
      for (int s = 1; s <= 4; s++) begin
         drive(4'b0101, 32'h1, 32'h7, 16'h0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd1, 1'b1);
         bus.fwd_rs_sel = 2'(s);
         bus.fwd_rt_sel = 2'(s);
         case (s)
            1:       exp_a = 32'h10;
            2:       exp_a = 32'h20;
            3:       exp_a = 32'h1;
            default: exp_a = 32'h1;
         endcase
         step();
         checks++;
         if (bus.alu_inpA !== exp_a) begin
            errors++;
            $display("FAIL fwd_rs_sel%0d got A=%h want %h", s & 3, bus.alu_inpA, exp_a);
         end
         checks++;
         if (bus.alu_inpB !== ((s == 3 || s == 4) ? 32'h7 : exp_a)) begin
            errors++;
            $display("FAIL fwd_rt_sel%0d got B=%h want %h", s & 3, bus.alu_inpB,
                     (s == 3 || s == 4) ? 32'h7 : exp_a);
         end
      end
   endtask

   task automatic test_shifts();
      drive(4'b0111, 32'h9, 32'h3, 16'h0, 1'b0, 5'd4, 1'b1, 2'b10, 5'd2, 1'b1);
      step();
      checks++;
      if (bus.alu_inpA !== 32'h3 || bus.alu_inpB !== 32'h4) begin
         errors++;
         $display("FAIL sll got A=%h B=%h want 3 4", bus.alu_inpA, bus.alu_inpB);
      end
      drive(4'b1000, 32'h7, 32'h80000000, 16'h0, 1'b0, 5'd1, 1'b1, 2'b11, 5'd2, 1'b1);
      step();
      checks++;
      if (bus.alu_inpA !== 32'h80000000 || bus.alu_inpB !== 32'h7) begin
         errors++;
         $display("FAIL srav got A=%h B=%h want 80000000 7", bus.alu_inpA, bus.alu_inpB);
      end
   endtask

   task automatic test_stall();
      drive(4'b0001, 32'hAA, 32'hBB, 16'h0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd4, 1'b1);
      step();
      drive(4'b0011, 32'hCC, 32'hDD, 16'h0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd6, 1'b0);
      bus.ex_ready = 1'b0;
      #1;
      checks++;
      if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL stall_id_ready got %0b want 0", bus.id_ready); end
      repeat (3) step();
      checks++;
      if (bus.alu_opcode !== 4'b0001 || bus.alu_inpA !== 32'hAA || bus.alu_inpB !== 32'hBB ||
          bus.ex_rd !== 5'd4 || bus.ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_frozen got op=%h A=%h B=%h rd=%0d v=%0b want 1 aa bb 4 1",
                  bus.alu_opcode, bus.alu_inpA, bus.alu_inpB, bus.ex_rd, bus.ex_valid);
      end
      checks++;
      if (bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d want 3", bus.stall_cnt); end
      bus.ex_ready = 1'b1;
      #1;
      checks++;
      if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL release_id_ready got %0b want 1", bus.id_ready); end
      step();
      checks++;
      if (bus.alu_opcode !== 4'b0011 || bus.alu_inpA !== 32'hCC || bus.ex_rd !== 5'd6 ||
          bus.ex_wr_en !== 1'b0 || bus.stall_cnt !== 16'd3) begin
         errors++;
         $display("FAIL release_capture got op=%h A=%h rd=%0d wr=%0b cnt=%0d want 3 cc 6 0 3",
                  bus.alu_opcode, bus.alu_inpA, bus.ex_rd, bus.ex_wr_en, bus.stall_cnt);
      end
   endtask

   task automatic test_flush();
      drive(4'b0100, 32'h55, 32'h66, 16'h0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd8, 1'b1);
      step();
      drive(4'b0110, 32'h77, 32'h88, 16'h0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd10, 1'b1);
      bus.ex_ready = 1'b0;
      bus.flush    = 1'b1;
      step();
      bus.flush = 1'b0;
      checks++;
      if (bus.ex_valid !== 1'b0 || bus.ex_wr_en !== 1'b0 || bus.alu_opcode !== 4'hF) begin
         errors++;
         $display("FAIL flush_squash got v=%0b wr=%0b op=%h want 0 0 f", bus.ex_valid, bus.ex_wr_en, bus.alu_opcode);
      end
      checks++;
      if (bus.alu_inpA !== 32'h55 || bus.stall_cnt !== 16'd4) begin
         errors++;
         $display("FAIL flush_hold got A=%h cnt=%0d want 55 4", bus.alu_inpA, bus.stall_cnt);
      end
      // Same instruction, flush gone: it is now accepted.
      step();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.alu_inpA !== 32'h77 || bus.ex_rd !== 5'd10) begin
         errors++;
         $display("FAIL after_flush got v=%0b A=%h rd=%0d want 1 77 10", bus.ex_valid, bus.alu_inpA, bus.ex_rd);
      end
   endtask

   task automatic test_saturation();
      // Count is 4 on entry; blocked for 65540 more edges it must pin at ffff.
      repeat (65540) step();
      checks++;
      if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got %h want ffff", bus.stall_cnt); end
      step();
      checks++;
      if (bus.stall_cnt !== 16'hFFFF || bus.ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_sat_hold got cnt=%h v=%0b want ffff 1", bus.stall_cnt, bus.ex_valid);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.flush     = 1'b0;
      bus.ex_ready  = 1'b1;
      bus.exmem_fwd = 32'h0;
      bus.memwb_fwd = 32'h0;
      drive(4'h0, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0);
      bus.id_valid = 1'b0;
      #12 rst_n = 1'b1;
      step();
      test_reset();
      test_add_imm();
      test_forwarding();
      test_shifts();
      test_stall();
      test_flush();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
